// File: rtl/full_conv_pkg.sv
// Shared sizes, types, FSM states and the multiply-term helper for the full_conv_core engine.
package full_conv_pkg;

  localparam int PIX_W   = 8;
  localparam int K_SIDE  = 5;
  localparam int KK      = K_SIDE * K_SIDE;
  localparam int NUM_KER = 6;
  localparam int IMG_MAX = 224;
  localparam int ACC_W   = 2 * PIX_W;

  typedef logic [PIX_W-1:0]        pixel_t;
  typedef logic signed [PIX_W-1:0] weight_t;
  typedef logic [ACC_W-1:0]        acc_t;
  typedef logic [KK*PIX_W-1:0]     kernel_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Caller zero-extends the pixel and sign-extends the weight to 32 bits.
  function automatic logic signed [31:0] mac_term(input logic [31:0] pix,
                                                  input logic signed [31:0] w);
    return $signed(pix) * w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 column-addressed row buffers feeding a KxK sliding window.
// Row buffer j holds, at each column, the pixel seen j+1 rows above the current row.
module conv_line_buffer import full_conv_pkg::*; #(
  parameter int W     = PIX_W,
  parameter int K     = K_SIDE,
  parameter int DEPTH = IMG_MAX,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [AW-1:0]    col,
  input  logic [W-1:0]     din,
  output logic [K*K*W-1:0] window
);

  logic [W-1:0] rows [K-1][DEPTH];
  logic [W-1:0] win [K][K];
  logic [W-1:0] new_col_s [K];

  // New window column: oldest row at index 0, the incoming pixel at index K-1.
  always_comb begin
    for (int i = 0; i < K-1; i++) new_col_s[i] = rows[K-2-i][col];
    new_col_s[K-1] = din;
  end

  // Row buffers age by one row per write at the same column.
  always_ff @(posedge clk) begin
    if (shift) begin
      rows[0][col] <= din;
      for (int j = 1; j < K-1; j++) rows[j][col] <= rows[j-1][col];
    end
  end

  // Window registers slide left by one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else if (shift) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= new_col_s[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) window[(i*K+j)*W +: W] = win[i][j];
  end

endmodule

// File: rtl/full_conv_core.sv
// full_conv_core: streaming valid-only KxK convolution, nok kernels in parallel.
// Define FULL_CONV_RELU_EN to clamp negative results to zero.
module full_conv_core import full_conv_pkg::*; #(
  parameter int N      = PIX_W - 1,
  parameter int nok    = NUM_KER,
  parameter int stride = K_SIDE,
  parameter int n      = K_SIDE,
  parameter int im     = IMG_MAX - K_SIDE + 1,
  parameter int img    = IMG_MAX
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N:0]                        data,
  input  logic                              data_valid,
  input  logic [nok*stride*stride*(N+1)-1:0] ker,
  input  logic [11:0]                       img_len,
  input  logic [2:0]                        ker_len,
  output logic                              data_request,
  output logic [nok*(2*N+2)-1:0]            out,
  output logic                              finish,
  output logic                              valid,
  output logic [N:0]                        valid_idx,
  output logic                              conv_fin
);

  localparam int K    = stride;
  localparam int KK_L = K * K;
  localparam int PW   = N + 1;
  localparam int OW   = 2 * N + 2;
  localparam int AW   = $clog2(img);
  localparam logic [11:0] KM1   = 12'(K - 1);
  localparam logic [2:0]  K_LEN = 3'(K);
  // An inconsistent parameter set never leaves IDLE.
  localparam bit PARAM_OK = (n == stride) && (im == img - stride + 1);

  state_t                  state_r;
  logic [nok*KK_L*PW-1:0]  ker_r;
  logic [11:0]             len_r, row_r, col_r, len_m1_s;
  logic [N:0]              col_off_s, win_col_r;
  logic                    win_ok_r, win_last_r;
  logic                    accept_s, last_s, full_s;
  logic [KK_L*PW-1:0]      window_s;
  logic [OW-1:0]           acc_s [nok];
  logic [nok*OW-1:0]       res_s;

  assign accept_s  = data_request && data_valid && (state_r == S_STREAM);
  assign len_m1_s  = len_r - 12'd1;
  assign last_s    = (row_r == len_m1_s) && (col_r == len_m1_s);
  assign full_s    = (row_r >= KM1) && (col_r >= KM1);
  assign col_off_s = col_r[N:0] - KM1[N:0];

  conv_line_buffer #(.W(PW), .K(K), .DEPTH(img), .AW(AW)) u_line_buffer (
    .clk    (clk),
    .reset  (reset),
    .shift  (accept_s),
    .col    (col_r[AW-1:0]),
    .din    (data),
    .window (window_s)
  );

  // Per-kernel dot product; summing modulo 2^OW equals truncating the full sum.
  always_comb begin
    res_s = '0;
    for (int k = 0; k < nok; k++) begin
      acc_s[k] = '0;
      for (int i = 0; i < KK_L; i++)
        acc_s[k] = acc_s[k] + OW'(mac_term(32'(window_s[i*PW +: PW]),
                                           32'(signed'(ker_r[(k*KK_L+i)*PW +: PW]))));
`ifdef FULL_CONV_RELU_EN
      res_s[k*OW +: OW] = acc_s[k][OW-1] ? '0 : acc_s[k];
`else
      res_s[k*OW +: OW] = acc_s[k];
`endif
    end
  end

  // Frame FSM, raster counters and the registered result stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      ker_r        <= '0;
      len_r        <= '0;
      row_r        <= '0;
      col_r        <= '0;
      win_ok_r     <= 1'b0;
      win_last_r   <= 1'b0;
      win_col_r    <= '0;
      data_request <= 1'b0;
      out          <= '0;
      finish       <= 1'b0;
      valid        <= 1'b0;
      valid_idx    <= '0;
      conv_fin     <= 1'b0;
    end else begin
      win_ok_r   <= 1'b0;
      win_last_r <= 1'b0;
      valid      <= win_ok_r;
      finish     <= win_last_r;
      if (win_ok_r) begin
        out       <= res_s;
        valid_idx <= win_col_r;
      end
      if (win_last_r) conv_fin <= 1'b1;
      case (state_r)
        S_IDLE: begin
          ker_r <= ker;
          len_r <= img_len;
          row_r <= '0;
          col_r <= '0;
          if (ker_len == K_LEN && PARAM_OK) begin
            state_r      <= S_STREAM;
            data_request <= 1'b1;
          end
        end
        S_STREAM: begin
          if (accept_s) begin
            win_ok_r   <= full_s;
            win_last_r <= full_s && last_s;
            win_col_r  <= col_off_s;
            if (col_r == len_m1_s) begin
              col_r <= '0;
              row_r <= row_r + 12'd1;
            end else begin
              col_r <= col_r + 12'd1;
            end
            if (last_s) begin
              data_request <= 1'b0;
              // A frame smaller than the kernel has no result to wait for.
              if (full_s) begin
                state_r <= S_DRAIN;
              end else begin
                state_r  <= S_DONE;
                conv_fin <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (win_last_r) state_r <= S_DONE;
        end
        S_DONE:  state_r <= S_DONE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_conv_core.sv
// Self-checking bench for full_conv_core: frames of known or random pixels scored
// against a direct windowed-sum model of the convolution.
`timescale 1ns/1ps
module tb_full_conv_core;

  localparam int K   = 5;
  localparam int NK  = 6;
  localparam int PW  = 8;
  localparam int OW  = 16;
  localparam int IMG = 224;

  logic                   clk = 1'b0;
  logic                   reset, data_valid, data_request, finish, valid, conv_fin;
  logic [PW-1:0]          data, valid_idx;
  logic [NK*K*K*PW-1:0]   ker;
  logic [11:0]            img_len;
  logic [2:0]             ker_len;
  logic [NK*OW-1:0]       out;

  full_conv_core dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid), .ker(ker),
    .img_len(img_len), .ker_len(ker_len), .data_request(data_request), .out(out),
    .finish(finish), .valid(valid), .valid_idx(valid_idx), .conv_fin(conv_fin)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int frame [IMG*IMG];
  int wts [NK][K*K];
  logic [NK*OW-1:0] obs_out [$];
  int               obs_idx [$];
  bit               obs_fin [$];
  int fin_count, fin_cyc, conv_fin_cyc, overrun, cycles;

  // Expected out vector for the e-th window of a len x len frame, straight from the definition.
  function automatic logic [NK*OW-1:0] model(input int len, input int e);
    int wo = len - K + 1;
    int r0 = e / wo;
    int c0 = e % wo;
    int s;
    logic [OW-1:0] t;
    logic [NK*OW-1:0] v = '0;
    for (int k = 0; k < NK; k++) begin
      s = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          s += frame[(r0+i)*len + c0 + j] * wts[k][i*K+j];
      t = 16'(s);
`ifdef FULL_CONV_RELU_EN
      if (s - 65536 * (s / 65536) != 0 && t[OW-1]) t = '0;
`endif
      v[k*OW +: OW] = t;
    end
    return v;
  endfunction

  task automatic load_ker();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < K*K; i++) ker[(k*K*K+i)*PW +: PW] = 8'(wts[k][i]);
  endtask

  task automatic randomize_frame(input int len);
    for (int i = 0; i < len*len; i++) frame[i] = int'($urandom_range(0, 255));
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < K*K; i++) wts[k][i] = int'($urandom_range(0, 255)) - 128;
    load_ker();
  endtask

  task automatic start(input int len, input logic [2:0] kl);
    reset = 1'b1; data_valid = 1'b0; img_len = 12'(len); ker_len = kl;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one frame and records every result; comparisons happen in the callers.
  task automatic run_frame(input int len, input bit toggle, input int abort_at);
    int idx = 0;
    int budget = len*len*(toggle ? 2 : 1) + 100;
    bit stop = 1'b0;
    obs_out.delete(); obs_idx.delete(); obs_fin.delete();
    fin_count = 0; fin_cyc = -1; conv_fin_cyc = -1; overrun = 0; cycles = 0;
    while (!stop) begin
      @(negedge clk);
      cycles++;
      if (valid) begin
        obs_out.push_back(out);
        obs_idx.push_back(int'(valid_idx));
        obs_fin.push_back(finish);
      end
      if (finish) begin fin_count++; fin_cyc = cycles; end
      if (conv_fin && conv_fin_cyc < 0) conv_fin_cyc = cycles;
      if (data_request && idx >= len*len) overrun++;
      data_valid = toggle ? cycles[0] : 1'b1;
      data = data_valid ? 8'(frame[(idx < len*len) ? idx : 0]) : 8'($urandom);
      if (data_request && data_valid && idx < len*len) idx++;
      if (abort_at >= 0 && idx >= abort_at) stop = 1'b1;
      if (conv_fin_cyc >= 0 && cycles >= conv_fin_cyc + 5) stop = 1'b1;
      if (cycles >= budget) stop = 1'b1;
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    data = '0; ker = '0;
    start(IMG, 3'd5);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({data_request, valid, finish, conv_fin} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: req/valid/finish/conv_fin=%b, required 0000",
               {data_request, valid, finish, conv_fin});
    end
    n_vec++;
    if (out !== '0 || valid_idx !== 8'd0) begin
      n_err++;
      $display("FAIL reset_data: out=%h idx=%0d, required 0 and 0", out, valid_idx);
    end
  endtask

  task automatic test_bad_ker_len();
    int bad = 0;
    start(12, 3'd3);
    data_valid = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (data_request !== 1'b0 || valid !== 1'b0 || conv_fin !== 1'b0) bad++;
    end
    data_valid = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bad_ker_len: %0d cycles with request/valid/conv_fin set, required 0", bad);
    end
  endtask

  task automatic test_full_frame();
    int wo = IMG - K + 1;
    logic [NK*OW-1:0] exp_v;
    for (int i = 0; i < IMG*IMG; i++) frame[i] = i % 256;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < K*K; i++) wts[k][i] = k + 1;
    load_ker();
    start(IMG, 3'd5);
    run_frame(IMG, 1'b0, -1);
    n_vec++;
    if (obs_out.size() != 48400) begin
      n_err++;
      $display("FAIL full_count: %0d results, required 48400", obs_out.size());
    end
    n_vec++;
    if (obs_out.size() == 0 || obs_idx[0] != 0 || obs_out[0][15:0] !== 16'd3570
        || obs_out[0][95:80] !== 16'd21420) begin
      n_err++;
      $display("FAIL full_first: first result missing or wrong, required idx 0, out0 3570, out5 21420");
    end
    for (int e = 0; e < obs_out.size(); e++) begin
      n_vec++;
      exp_v = model(IMG, e);
      if (obs_out[e] !== exp_v || obs_idx[e] != e % wo) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL full_result %0d: out=%h idx=%0d, required out=%h idx=%0d",
                   e, obs_out[e], obs_idx[e], exp_v, e % wo);
      end
    end
    n_vec++;
    if (fin_count != 1 || fin_cyc != conv_fin_cyc || obs_fin.size() == 0
        || obs_fin[obs_fin.size()-1] != 1'b1) begin
      n_err++;
      $display("FAIL full_finish: %0d pulses at cycle %0d, conv_fin at %0d, required one pulse on last result",
               fin_count, fin_cyc, conv_fin_cyc);
    end
    n_vec++;
    if (conv_fin_cyc != 50178) begin
      n_err++;
      $display("FAIL full_latency: conv_fin at cycle %0d, required 50178", conv_fin_cyc);
    end
    n_vec++;
    if (overrun != 0 || conv_fin !== 1'b1) begin
      n_err++;
      $display("FAIL full_end: request after last pixel %0d cycles, conv_fin=%b, required 0 and 1",
               overrun, conv_fin);
    end
  endtask

  // Random frame scored end to end; toggle halves the input rate.
  task automatic test_random_frame(input int len, input bit toggle);
    int wo = len - K + 1;
    logic [NK*OW-1:0] exp_v;
    start(len, 3'd5);
    run_frame(len, toggle, -1);
    n_vec++;
    if (obs_out.size() != wo*wo || fin_count != 1 || conv_fin_cyc < 0 || fin_cyc != conv_fin_cyc) begin
      n_err++;
      $display("FAIL random_frame len=%0d toggle=%0d: %0d results %0d finish, conv_fin at %0d, required %0d and 1",
               len, toggle, obs_out.size(), fin_count, conv_fin_cyc, wo*wo);
    end
    for (int e = 0; e < obs_out.size(); e++) begin
      n_vec++;
      exp_v = model(len, e);
      if (obs_out[e] !== exp_v || obs_idx[e] != e % wo) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL random_result %0d toggle=%0d: out=%h idx=%0d, required out=%h idx=%0d",
                   e, toggle, obs_out[e], obs_idx[e], exp_v, e % wo);
      end
    end
  endtask

  task automatic test_negative();
    logic [OW-1:0] neg_exp;
`ifdef FULL_CONV_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hE719;
`endif
    for (int i = 0; i < 49; i++) frame[i] = 255;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < K*K; i++) wts[k][i] = -1;
    load_ker();
    start(7, 3'd5);
    run_frame(7, 1'b0, -1);
    n_vec++;
    if (obs_out.size() != 9) begin
      n_err++;
      $display("FAIL negative_count: %0d results, required 9", obs_out.size());
    end
    for (int e = 0; e < obs_out.size(); e++) begin
      n_vec++;
      if (obs_out[e] !== {NK{neg_exp}}) begin
        n_err++;
        $display("FAIL negative_result %0d: out=%h, required %h in every kernel", e, obs_out[e], neg_exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    randomize_frame(12);
    start(12, 3'd5);
    run_frame(12, 1'b0, 100);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({data_request, valid, finish, conv_fin} !== 4'b0000 || out !== '0 || valid_idx !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset: req/valid/finish/conv_fin=%b out=%h idx=%0d, required all 0",
               {data_request, valid, finish, conv_fin}, out, valid_idx);
    end
    test_random_frame(12, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bad_ker_len();
    test_full_frame();
    randomize_frame(12);
    test_random_frame(12, 1'b0);
    test_random_frame(12, 1'b1);
    randomize_frame(9);
    test_random_frame(9, 1'b1);
    test_negative();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
